uart_tx_stim: RTL and testbench
===============================

# uart_tx_stim

Buffered 8N1 UART transmitter that serializes bytes onto a single TX line at a fixed bit time. It is the transmit-side counterpart of the serial terminal: it drives the SoC's `RsRx_Sys0_SS0_*` inputs from a simple valid/ready byte interface. It also serves as a reusable synthesizable TX engine for peripheral subsystems. A small internal FIFO lets a producer queue a burst of characters. Frames are sent back-to-back with no idle gap.

## Interface
- `CLKS_PER_BIT`, 16, HCLK cycles per bit (16 = 160 ns at 10 ns HCLK); legal range ≥ 2
- `FIFO_DEPTH`, 4, byte entries; power of two, ≥ 2
- `HCLK` in 1 system clock; all logic on rising edge
- `HRESETn` in 1 asynchronous, active-low reset
- `wdata` in 8 byte to queue
- `wvalid` in 1 producer has a byte on `wdata`
- `wready` out 1 FIFO can accept; a byte transfers on an edge with `wvalid & wready`
- `tx` out 1 serial line, idle high; registered
- `busy` out 1 a frame is in progress (state ≠ IDLE)
- `level` out $clog2(FIFO_DEPTH)+1 bytes currently queued, excluding the byte being shifted

## Operation
- Reset values: `tx`=1, `busy`=0, `level`=0, `wready`=1. FIFO pointers, bit counter and cycle counter are all 0. State is IDLE.
- `wready` = !full, combinational from registered `level` only. A pop in the same cycle does not let a push through when the FIFO is full.
- Simultaneous push and pop when the FIFO is not full leaves `level` unchanged, and data order is preserved.
- State machine: IDLE → START → DATA → (PARITY, see Configuration) → STOP → IDLE or START.
  - IDLE, FIFO non-empty: pop the head into the shift register, set `tx`=0, go to START.
  - START: hold for CLKS_PER_BIT cycles, then drive the shift register LSB and go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. The shift register shifts right once per bit.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On its last cycle:
    - FIFO non-empty: pop and go directly to START, so `tx` goes 0 on the next cycle.
    - Otherwise go to IDLE.
- Cycle counter runs 0..CLKS_PER_BIT-1 within each bit. The bit counter counts 0..7 in DATA. Counter widths are $clog2 of their ranges.
- Frame length: 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with parity).
- Reset asserted mid-frame: `tx` returns to 1 asynchronously, and the FIFO contents and partial frame are discarded.
- `wdata` is ignored when `wvalid` is low. No other inputs affect an in-flight frame.

## Timing
- Write accepted at edge N into an empty FIFO while IDLE: `level`=1 after N. The pop happens at N+1 and `tx` falls at N+1, so `level` returns to 0 after N+1.
- Start bit spans edges N+1 … N+1+CLKS_PER_BIT. Data bit k begins at N+1+(k+1)·CLKS_PER_BIT. The stop bit begins at N+1+9·CLKS_PER_BIT.
- `busy` rises with the falling `tx` at N+1. It falls one edge after the last stop-bit cycle when no byte is queued.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop cycle (zero idle cycles).

## Configuration
- `UART_TX_STIM_PARITY_EN`
- Defined: a PARITY state sits between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, making the frame 11 bits.
- Undefined: no PARITY state or parity logic; the frame is 10 bits.

## Test plan
- Single byte, CLKS_PER_BIT=16: write 0x41 at edge N.
  - `tx` low for 16 cycles from N+1.
  - Data bits sampled mid-bit are 1,0,0,0,0,0,1,0, then stop=1.
  - `busy` high for exactly 160 cycles.
  - A terminal-style receiver (bit_time 160 ns) prints "A".
- Back-to-back: write 0x55 and 0xAA on consecutive edges.
  - The second start bit begins exactly 160 cycles after the first.
  - No high idle cycle between the first stop bit and the second start bit.
- Backpressure, FIFO_DEPTH=4: hold `wvalid` for 6 bytes starting at edge N.
  - Bytes 1–5 are accepted on N…N+4 (byte 1 popped at N+1), so `level`=4 and `wready`=0.
  - The 6th byte is accepted on the edge after byte 2's start bit begins.
  - All 6 bytes emerge in order.
- Full plus pop: FIFO full at the end of a frame with `wvalid` high. On the pop edge `level` drops to 3 and nothing is accepted. The write is accepted on the next edge.
- Reset mid-frame: assert `HRESETn`=0 during data bit 3 of 0x00 with 2 bytes queued.
  - `tx`=1 immediately; `level`=0 and `busy`=0.
  - After release with no writes, `tx` stays high for 500 cycles.
- Parity (macro defined):
  - 0x07: bit 9 = 1 and the frame is 176 cycles.
  - 0x03: bit 9 = 0.

Source files
------------

// File: rtl/uart_tx_stim_if.sv
// Byte write channel into the uart_tx_stim transmit FIFO.
//   wdata  : byte to queue
//   wvalid : producer has a byte on wdata
//   wready : FIFO can accept; a byte transfers on an edge with wvalid & wready
interface uart_tx_stim_if;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;

    modport master (output wdata, output wvalid, input wready);
    modport slave  (input wdata, input wvalid, output wready);
endinterface

// File: rtl/uart_tx_stim.sv
// Buffered 8N1 UART transmitter: queues bytes in a small FIFO and shifts them
// out LSB first at CLKS_PER_BIT clocks per bit, frames back-to-back.
// Optional even parity bit between data and stop: define UART_TX_STIM_PARITY_EN.
//   HCLK    : system clock, rising edge
//   HRESETn : asynchronous active-low reset
//   wr      : byte write channel (slave side)
//   tx      : serial line, idle high, registered
//   busy    : a frame is in progress
//   level   : bytes queued, excluding the byte being shifted
module uart_tx_stim #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    uart_tx_stim_if.slave               wr,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = 3;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(7);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

`ifdef UART_TX_STIM_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Frame engine state
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_d;
    logic          load;
`ifdef UART_TX_STIM_PARITY_EN
    logic          par_q, par_d;
`endif

    // Ready depends on the registered level only, so a same-cycle pop never frees a slot early
    assign full      = (level == LVL_FULL);
    assign empty     = (level == '0);
    assign wr.wready = !full;
    assign push      = wr.wvalid & !full;
    assign pop       = load;

    // Byte storage, no reset needed
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= wr.wdata;
        end
    end

    // Occupancy update
    always_comb begin
        level_d = level;
        case ({push, pop})
            2'b10:   level_d = level + LW'(1);
            2'b01:   level_d = level - LW'(1);
            default: level_d = level;
        endcase
    end

    // FIFO pointers and level
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_d;
        end
    end

    // Next-state and next-output logic for the frame engine
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx;
        load    = 1'b0;
`ifdef UART_TX_STIM_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                load = !empty;
            end

            START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_STIM_PARITY_EN
                        tx_d    = par_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

`ifdef UART_TX_STIM_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = IDLE;
                    load    = !empty;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        // Starting a frame (from IDLE or straight off the last stop cycle) overrides the above
        if (load) begin
            shreg_d = mem[rd_ptr];
            tx_d    = 1'b0;
            cnt_d   = '0;
            state_d = START;
`ifdef UART_TX_STIM_PARITY_EN
            par_d   = ^mem[rd_ptr];
`endif
        end
    end

    // Frame engine registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_TX_STIM_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx      <= tx_d;
            busy    <= (state_d != IDLE);
`ifdef UART_TX_STIM_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_stim.sv
// Testbench for uart_tx_stim: frame-level reference model checked every cycle,
// a bit-sampling receiver, and directed literal checks for the key timings.
module tb_uart_tx_stim;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_TX_STIM_PARITY_EN
    localparam int NBITS = 11;
    localparam int FRAME_LIT = 176;
`else
    localparam int NBITS = 10;
    localparam int FRAME_LIT = 160;
`endif
    localparam int FRAME = NBITS * CPB;
    localparam int TRMAX = 1200;

    logic       HCLK    = 1'b0;
    logic       HRESETn = 1'b0;
    logic       tx;
    logic       busy;
    logic [2:0] level;

    uart_tx_stim_if wr_if ();

    uart_tx_stim #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .wr      (wr_if.slave),
        .tx      (tx),
        .busy    (busy),
        .level   (level)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];
    logic [7:0] rx_exp[$];
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = 8'h00;
    bit         m_take;
    logic [7:0] m_din;

    // Line value for bit slot idx of a frame carrying b
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_STIM_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_q.delete();
            rx_exp.delete();
            m_active = 1'b0;
            m_pos    = 0;
        end else begin
            m_take = wr_if.wvalid && (m_q.size() < DEPTH);
            m_din  = wr_if.wdata;
            if (m_active && m_pos != FRAME - 1) begin
                m_pos++;
            end else if (m_q.size() > 0) begin
                m_byte   = m_q.pop_front();
                rx_exp.push_back(m_byte);
                m_active = 1'b1;
                m_pos    = 0;
            end else begin
                m_active = 1'b0;
            end
            if (m_take) m_q.push_back(m_din);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge HCLK) begin
        if (cmp_en) begin
            check("tx",     32'(tx),           32'(m_active ? frame_bit(m_byte, m_pos / CPB) : 1'b1));
            check("busy",   32'(busy),         32'(m_active));
            check("level",  32'(level),        32'(m_q.size()));
            check("wready", 32'(wr_if.wready), 32'(m_q.size() < DEPTH));
        end
    end

    // ---------------- line receiver ----------------
    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_byte   = 8'h00;
    int         rx_frames = 0;

    always @(negedge HCLK) begin
        if (!HRESETn || !cmp_en) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx == 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_byte[rx_cnt / CPB - 1] = tx;
`ifdef UART_TX_STIM_PARITY_EN
                if (rx_cnt / CPB == 9) check("rx_parity", 32'(tx), 32'(^rx_byte));
`endif
                if (rx_cnt / CPB == NBITS - 1) begin
                    check("rx_stop", 32'(tx), 32'(1));
                    if (rx_exp.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_byte: got %02h with no byte outstanding at t=%0t", rx_byte, $time);
                    end else begin
                        check("rx_byte", 32'(rx_byte), 32'(rx_exp.pop_front()));
                    end
                    rx_frames++;
                    rx_active = 1'b0;
                end
            end
        end
    end

    // ---------------- directed stimulus helpers ----------------
    logic       tr_tx   [0:TRMAX-1];
    logic       tr_busy [0:TRMAX-1];
    logic [2:0] tr_lvl  [0:TRMAX-1];
    logic       tr_rdy  [0:TRMAX-1];
    logic [7:0] src[$];
    int         acc_edge[$];

    // Called at a negedge; the next posedge is edge N (index 0). tr_*[i] holds outputs after edge N+i.
    task automatic run(input int n);
        logic will_take;
        acc_edge.delete();
        for (int i = 0; i < n; i++) begin
            if (src.size() > 0) begin
                wr_if.wvalid = 1'b1;
                wr_if.wdata  = src[0];
            end else begin
                wr_if.wvalid = 1'b0;
            end
            will_take = wr_if.wvalid && wr_if.wready;
            @(negedge HCLK);
            if (will_take) begin
                void'(src.pop_front());
                acc_edge.push_back(i);
            end
            tr_tx[i]   = tx;
            tr_busy[i] = busy;
            tr_lvl[i]  = level;
            tr_rdy[i]  = wr_if.wready;
        end
        wr_if.wvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((busy || level != 3'd0) && c < 5000) begin
            @(negedge HCLK);
            c++;
        end
        check("wait_idle_in_time", 32'(c < 5000), 32'(1));
    endtask

    function automatic int busy_count(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(tr_busy[i]);
        return s;
    endfunction

    logic a_bits [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [7:0] dec;
        int hi;
        int pct;

        wr_if.wvalid = 1'b0;
        wr_if.wdata  = 8'h00;
        HRESETn      = 1'b0;
        repeat (3) @(negedge HCLK);
        check("rst_tx",     32'(tx),           32'(1));
        check("rst_busy",   32'(busy),         32'(0));
        check("rst_level",  32'(level),        32'(0));
        check("rst_wready", 32'(wr_if.wready), 32'(1));
        HRESETn = 1'b1;
        cmp_en  = 1'b1;
        @(negedge HCLK);

        // Single byte 'A'
        src = '{8'h41};
        run(FRAME + 10);
        check("a_acc_edge",  32'(acc_edge[0]), 32'(0));
        check("a_lvl_N",     32'(tr_lvl[0]),   32'(1));
        check("a_tx_N",      32'(tr_tx[0]),    32'(1));
        check("a_busy_N",    32'(tr_busy[0]),  32'(0));
        check("a_lvl_N1",    32'(tr_lvl[1]),   32'(0));
        check("a_tx_N1",     32'(tr_tx[1]),    32'(0));
        check("a_busy_N1",   32'(tr_busy[1]),  32'(1));
        check("a_start_end", 32'(tr_tx[16]),   32'(0));
        check("a_bit0_beg",  32'(tr_tx[17]),   32'(1));
        for (int k = 0; k < 8; k++) begin
            dec[k] = tr_tx[1 + (k + 1) * CPB + CPB / 2];
            check("a_data_bit", 32'(dec[k]), 32'(a_bits[k]));
        end
        check("a_char",      32'(dec), 32'(8'h41));
        check("a_stop",      32'(tr_tx[1 + (NBITS - 1) * CPB + CPB / 2]), 32'(1));
        check("a_busy_len",  32'(busy_count(FRAME + 10)), 32'(FRAME_LIT));
        check("a_busy_fall", 32'(tr_busy[FRAME_LIT + 1]), 32'(0));

        // Back-to-back 0x55, 0xAA
        wait_idle();
        src = '{8'h55, 8'hAA};
        run(2 * FRAME + 10);
        check("b2b_acc0",     32'(acc_edge[0]), 32'(0));
        check("b2b_acc1",     32'(acc_edge[1]), 32'(1));
        check("b2b_last_stop", 32'(tr_tx[FRAME_LIT]),     32'(1));
        check("b2b_start2",    32'(tr_tx[FRAME_LIT + 1]), 32'(0));
        hi = 0;
        for (int i = 1 + (NBITS - 1) * CPB; i <= FRAME + CPB; i++) hi += int'(tr_tx[i]);
        check("b2b_high_gap",  32'(hi), 32'(16));
        check("b2b_busy_len",  32'(busy_count(2 * FRAME + 10)), 32'(2 * FRAME_LIT));

        // Backpressure and full-plus-pop
        wait_idle();
        src = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
        run(6 * FRAME + 20);
        check("bp_acc_cnt", 32'(acc_edge.size()), 32'(6));
        for (int i = 0; i < 5; i++) check("bp_acc_edge", 32'(acc_edge[i]), 32'(i));
        check("bp_acc6",     32'(acc_edge[5]),         32'(FRAME_LIT + 2));
        check("bp_lvl_N4",   32'(tr_lvl[4]),           32'(4));
        check("bp_rdy_N4",   32'(tr_rdy[4]),           32'(0));
        check("bp_rdy_full", 32'(tr_rdy[FRAME_LIT]),   32'(0));
        check("bp_lvl_pop",  32'(tr_lvl[FRAME_LIT + 1]), 32'(3));
        check("bp_lvl_push", 32'(tr_lvl[FRAME_LIT + 2]), 32'(4));
        hi = rx_frames;
        wait_idle();
        check("bp_frames", 32'(rx_frames - hi), 32'(0));
        check("bp_rx_backlog", 32'(rx_exp.size()), 32'(0));

        // Reset during data bit 3 of 0x00 with two bytes queued
        src = '{8'h00, 8'h11, 8'h22};
        run(1 + 4 * CPB + CPB / 2);
        check("rr_tx_bit3", 32'(tx),    32'(0));
        check("rr_level",   32'(level), 32'(2));
        #2 HRESETn = 1'b0;
        #1;
        check("rr_tx_async",    32'(tx),           32'(1));
        check("rr_level_async", 32'(level),        32'(0));
        check("rr_busy_async",  32'(busy),         32'(0));
        check("rr_wready",      32'(wr_if.wready), 32'(1));
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        hi = 0;
        repeat (500) begin
            @(negedge HCLK);
            hi += int'(tx);
        end
        check("rr_idle_500", 32'(hi),   32'(500));
        check("rr_busy_idle", 32'(busy), 32'(0));

`ifdef UART_TX_STIM_PARITY_EN
        src = '{8'h07};
        run(FRAME + 10);
        check("par07_bit9", 32'(tr_tx[1 + 9 * CPB + CPB / 2]), 32'(1));
        check("par07_len",  32'(busy_count(FRAME + 10)), 32'(176));
        wait_idle();
        src = '{8'h03};
        run(FRAME + 10);
        check("par03_bit9", 32'(tr_tx[1 + 9 * CPB + CPB / 2]), 32'(0));
        wait_idle();
`endif

        // Randomized traffic at three write densities
        for (int ph = 0; ph < 3; ph++) begin
            pct = (ph == 0) ? 10 : (ph == 1) ? 40 : 95;
            repeat (1000) begin
                wr_if.wvalid = ($urandom_range(99) < 32'(pct));
                wr_if.wdata  = 8'($urandom);
                @(negedge HCLK);
            end
        end
        wr_if.wvalid = 1'b0;
        wait_idle();
        repeat (4) @(negedge HCLK);
        check("rand_rx_backlog", 32'(rx_exp.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
